// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one word request at a
// time to instruction memory (req/ack), buffers returned words tagged with
// their PC in a small circular queue, and hands them to decode (valid/ready).
// A redirect from execute flushes the queue and restarts fetch at the target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2            // 2 or 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    input  logic        INSTR_READY
);

    localparam int PW = $clog2(QDEPTH);      // queue pointer width
    localparam int CW = $clog2(QDEPTH + 1);  // occupancy counter width

    localparam logic [1:0] IDLE = 2'd0;  // no request outstanding
    localparam logic [1:0] REQ  = 2'd1;  // request outstanding, data will be kept
    localparam logic [1:0] DROP = 2'd2;  // request outstanding, data will be discarded

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t [QDEPTH-1:0] q;
    logic   [PW-1:0]     head;
    logic   [PW-1:0]     tail;
    logic   [CW-1:0]     count;
    logic   [CW-1:0]     count_nxt;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic        req_r;
    logic [31:0] addr_r;

    logic        push;
    logic        pop;
    logic        room;
    logic [31:0] tgt;
    logic [31:0] addr_inc;

    // Low two target bits are masked off; redirect targets are word aligned.
    assign tgt      = REDIRECT_PC & ~32'h0000_0003;
    assign addr_inc = addr_r + 32'd4;

    // Redirect outranks both queue ports: the acked word and the head are
    // simply thrown away along with the rest of the queue.
    assign push = (state == REQ) && IMEM_ACK && !REDIRECT;
    assign pop  = INSTR_VALID && INSTR_READY && !REDIRECT;

    // Occupancy after this cycle's push/pop; also decides whether fetch may
    // continue, so a same-cycle pop frees a slot without a bubble.
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    assign room = (count_nxt < CW'(QDEPTH));

    assign IMEM_REQ    = req_r;
    assign IMEM_ADDR   = addr_r;
    assign INSTR_VALID = (count != '0);
    assign INSTR       = q[head].instr;
    assign INSTR_PC    = q[head].pc;

    // Instruction queue: circular buffer, flushed by redirect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++)
                q[i] <= '0;
        end else if (REDIRECT) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q[tail] <= '{instr: IMEM_RDATA, pc: addr_r};
                tail    <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count_nxt;
        end
    end

    // Fetch FSM: at most one request in flight; req/addr never change while
    // a request waits for its ack, even across a redirect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            req_r    <= 1'b0;
            addr_r   <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (REDIRECT) begin
                        fetch_pc <= tgt;
                        req_r    <= 1'b1;
                        addr_r   <= tgt;
                        state    <= REQ;
                    end else if (room) begin
                        req_r  <= 1'b1;
                        addr_r <= fetch_pc;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (REDIRECT) begin
                        fetch_pc <= tgt;
                        if (IMEM_ACK)
                            addr_r <= tgt;  // old request done, start the new one
                        else
                            state  <= DROP; // keep old request up until acked
                    end else if (IMEM_ACK) begin
                        fetch_pc <= addr_inc;
                        if (room) begin
                            addr_r <= addr_inc;
                        end else begin
                            req_r <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (REDIRECT)
                        fetch_pc <= tgt;
                    if (IMEM_ACK) begin
                        addr_r <= REDIRECT ? tgt : fetch_pc;
                        state  <= REQ;
                    end
                end
                default: begin
                    req_r <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios drive redirect/ready and a
// behavioural memory; expected {pc, instr} pairs go into a scoreboard queue
// and a monitor compares every accepted instruction against it.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic        INSTR_VALID;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_READY = 1'b0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
        .IMEM_RDATA(IMEM_RDATA), .INSTR_VALID(INSTR_VALID), .INSTR(INSTR),
        .INSTR_PC(INSTR_PC), .INSTR_READY(INSTR_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ack_log[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          pop_cnt = 0;
    int          ack_cnt = 0;
    int          lat = 0;
    bit          hold = 1'b0;
    int          wcnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        tick();
        RST = 1'b1;
        INSTR_READY = 1'b0;
        REDIRECT = 1'b0;
        hold = 1'b0;
        repeat (2) tick();
        sb.delete();
        ack_log.delete();
        ack_cnt = 0;
    endtask

    // Returns right after the posedge that performs the n-th pop.
    task automatic wait_pops(input int n, input string name);
        int tgt;
        int c;
        tgt = pop_cnt + n;
        c = 0;
        while (pop_cnt < tgt && c < 300) begin
            tick();
            c++;
        end
        checks++;
        if (pop_cnt < tgt) begin
            failures++;
            $display("FAIL %s: timeout, pops %0d required %0d", name, pop_cnt, tgt);
        end
    endtask

    // Monitor: every accepted head must match the scoreboard front.
    always @(negedge CLK) begin
        if (!RST && INSTR_VALID && INSTR_READY && !REDIRECT) begin
            pop_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_instr: got pc %h instr %h, none expected", INSTR_PC, INSTR);
            end else begin
                mon_e = sb.pop_front();
                if (INSTR_PC !== mon_e.pc || INSTR !== mon_e.instr) begin
                    failures++;
                    $display("FAIL instr_out: got pc %h instr %h expected pc %h instr %h",
                             INSTR_PC, INSTR, mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    // Memory model: acks after `lat` wait cycles unless held; checks that a
    // waiting request keeps req and address stable.
    always @(negedge CLK) begin
        if (RST) begin
            IMEM_ACK = 1'b0;
            wcnt = 0;
            pend = 1'b0;
        end else begin
            if (pend) begin
                checks++;
                if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== pend_addr) begin
                    failures++;
                    $display("FAIL req_hold: got req %b addr %h expected req 1 addr %h",
                             IMEM_REQ, IMEM_ADDR, pend_addr);
                end
            end
            if (IMEM_REQ && !hold && wcnt >= lat) begin
                IMEM_ACK = 1'b1;
                IMEM_RDATA = mem_word(IMEM_ADDR);
                ack_log.push_back(IMEM_ADDR);
                ack_cnt++;
                wcnt = 0;
                pend = 1'b0;
            end else begin
                IMEM_ACK = 1'b0;
                IMEM_RDATA = 32'h0;
                if (IMEM_REQ) begin
                    if (!hold) wcnt++;
                    pend = 1'b1;
                    pend_addr = IMEM_ADDR;
                end else begin
                    wcnt = 0;
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int p0;

        // Reset values
        do_reset();
        chk("rst_req", {31'h0, IMEM_REQ}, 32'h0);
        chk("rst_addr", IMEM_ADDR, 32'h0);
        chk("rst_valid", {31'h0, INSTR_VALID}, 32'h0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_pc", INSTR_PC, 32'h0);

        // Zero-wait streaming, READY=1: 0,4,...,28 with no gaps
        lat = 0;
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        INSTR_READY = 1'b1;
        RST = 1'b0;
        p0 = pop_cnt;
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 1) begin
                chk("first_req", {31'h0, IMEM_REQ}, 32'h1);
                chk("first_addr", IMEM_ADDR, 32'h0);
            end
        end while (pop_cnt < p0 + 8 && cyc < 100);
        INSTR_READY = 1'b0;
        chk("stream_cycles", 32'(cyc), 32'd10);

        // READY=0: queue fills after two acks, then one pop restarts fetch at 8
        do_reset();
        lat = 0;
        RST = 1'b0;
        repeat (6) tick();
        chk("full_acks", 32'(ack_cnt), 32'd2);
        chk("full_req", {31'h0, IMEM_REQ}, 32'h0);
        chk("full_valid", {31'h0, INSTR_VALID}, 32'h1);
        chk("full_pc", INSTR_PC, 32'h0);
        chk("full_instr", INSTR, mem_word(32'h0));
        expect_pc(32'h0);
        INSTR_READY = 1'b1;
        tick();
        INSTR_READY = 1'b0;
        chk("refill_req", {31'h0, IMEM_REQ}, 32'h1);
        chk("refill_addr", IMEM_ADDR, 32'h8);
        chk("refill_head", INSTR_PC, 32'h4);

        // 3-cycle memory latency
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) expect_pc(32'(i * 4));
        INSTR_READY = 1'b1;
        RST = 1'b0;
        wait_pops(3, "lat3_pops");
        INSTR_READY = 1'b0;
        chk("lat3_ack1", (ack_log.size() > 1) ? ack_log[1] : 32'hDEAD, 32'h4);

        // Redirect while request for 8 waits: DROP, then refetch at 0x100
        do_reset();
        lat = 0;
        RST = 1'b0;
        repeat (6) tick();
        hold = 1'b1;
        expect_pc(32'h0);
        INSTR_READY = 1'b1;
        tick();
        INSTR_READY = 1'b0;
        tick();
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0100;
        tick();
        REDIRECT = 1'b0;
        chk("drop_req", {31'h0, IMEM_REQ}, 32'h1);
        chk("drop_addr", IMEM_ADDR, 32'h8);
        chk("drop_flush", {31'h0, INSTR_VALID}, 32'h0);
        repeat (2) tick();
        chk("drop_valid", {31'h0, INSTR_VALID}, 32'h0);
        hold = 1'b0;
        expect_pc(32'h100);
        expect_pc(32'h104);
        INSTR_READY = 1'b1;
        wait_pops(2, "drop_pops");
        INSTR_READY = 1'b0;
        chk("drop_ack8", (ack_log.size() > 2) ? ack_log[2] : 32'hDEAD, 32'h8);
        chk("drop_next", (ack_log.size() > 3) ? ack_log[3] : 32'hDEAD, 32'h100);

        // Redirect to misaligned 0x203 in the same cycle as an ack
        do_reset();
        lat = 0;
        RST = 1'b0;
        tick();
        tick();
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0203;
        tick();
        REDIRECT = 1'b0;
        chk("redir_ack_flush", {31'h0, INSTR_VALID}, 32'h0);
        chk("redir_ack_req", {31'h0, IMEM_REQ}, 32'h1);
        chk("redir_ack_addr", IMEM_ADDR, 32'h200);
        expect_pc(32'h200);
        expect_pc(32'h204);
        INSTR_READY = 1'b1;
        tick();
        chk("redir_first_valid", {31'h0, INSTR_VALID}, 32'h1);
        chk("redir_first_pc", INSTR_PC, 32'h200);
        wait_pops(2, "redir_ack_pops");
        INSTR_READY = 1'b0;
        chk("redir_ack_dropped", (ack_log.size() > 1) ? ack_log[1] : 32'hDEAD, 32'h4);

        // PC wrap at 0xFFFF_FFFC, then reset mid-request
        do_reset();
        lat = 0;
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'hFFFF_FFFC;
        RST = 1'b0;
        tick();
        REDIRECT = 1'b0;
        chk("wrap_addr0", IMEM_ADDR, 32'hFFFF_FFFC);
        tick();
        hold = 1'b1;
        chk("wrap_req", {31'h0, IMEM_REQ}, 32'h1);
        chk("wrap_addr1", IMEM_ADDR, 32'h0);
        tick();
        chk("wrap_head_pc", INSTR_PC, 32'hFFFF_FFFC);
        chk("wrap_head_instr", INSTR, mem_word(32'hFFFF_FFFC));
        RST = 1'b1;
        tick();
        chk("midrst_req", {31'h0, IMEM_REQ}, 32'h0);
        chk("midrst_addr", IMEM_ADDR, 32'h0);
        chk("midrst_valid", {31'h0, INSTR_VALID}, 32'h0);
        chk("midrst_instr", INSTR, 32'h0);
        chk("midrst_pc", INSTR_PC, 32'h0);
        hold = 1'b0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
